uart_tx_ctrl: RTL

UART transmit controller. It accepts a parallel byte over a valid/ready handshake and serialises it onto the `tx` line as a start bit, data bits (LSB first), an optional parity bit and stop bits. It sequences an internal per-bit baud-tick counter and a bit-index counter, and sits between the host/FIFO side and the UART pad.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_baud_tick.sv | 33 +++
 rtl/uart_tx_ctrl.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and width helpers for the UART transmit path.
package uart_pkg;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_e;

  // Bit-index width; a floor of 1 keeps the vector legal for any DATA_BITS.
  function automatic int bit_cnt_w(input int data_bits);
    return (data_bits > 1) ? $clog2(data_bits) : 1;
  endfunction

  function automatic int baud_cnt_w(input int clks_per_bit);
    return (clks_per_bit > 1) ? $clog2(clks_per_bit) : 1;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Per-bit baud counter: counts 0..CLKS_PER_BIT-1 while enabled and flags the
// last cycle of each serial bit.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic bit_end
);

  localparam int CW = baud_cnt_w(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable) begin
      if (cnt_q == CNT_LAST) cnt_q <= '0;
      else                   cnt_q <= cnt_q + CW'(1);
    end
  end

  assign bit_end = enable && (cnt_q == CNT_LAST);

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: serialises one word per accepted handshake as
// start, data (LSB first), optional parity and stop bits on a registered line.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 tx_done,
  output tx_state_e            state_dbg
);

  localparam int IW = bit_cnt_w(DATA_BITS);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_ctrl: DATA_BITS must be 5..9");
  end
  if (CLKS_PER_BIT < 2) begin : g_bad_clks
    $error("uart_tx_ctrl: CLKS_PER_BIT must be >= 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx_ctrl: STOP_BITS must be 1 or 2");
  end

  tx_state_e            state_q, state_d;
  logic                 tx_q, tx_d;
  logic [DATA_BITS-1:0] shreg_q;
  logic                 parity_q;
  logic [IW-1:0]        bit_idx_q;
  logic                 stop_cnt_q;
  logic                 tx_done_q;

  logic load, shift, idx_inc, stop_inc, stop_clr, done_d;
  logic bit_end;

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (load),
    .enable  (busy),
    .bit_end (bit_end)
  );

  // Handshake: a word transfers on a rising edge where tx_valid && tx_ready;
  // tx_ready is high only in IDLE, so inputs are ignored for the whole frame
  // and the host must hold tx_valid/tx_data stable until that edge.
  always_comb begin
    state_d  = state_q;
    tx_d     = tx_q;
    load     = 1'b0;
    shift    = 1'b0;
    idx_inc  = 1'b0;
    stop_inc = 1'b0;
    stop_clr = 1'b0;
    done_d   = 1'b0;
    unique case (state_q)
      TX_IDLE: begin
        tx_d = 1'b1;
        if (tx_valid) begin
          state_d = TX_START;
          tx_d    = 1'b0;
          load    = 1'b1;
        end
      end
      TX_START: begin
        if (bit_end) begin
          state_d = TX_DATA;
          tx_d    = shreg_q[0];
        end
      end
      TX_DATA: begin
        if (bit_end) begin
          shift = 1'b1;
          if (bit_idx_q == IDX_LAST) begin
            if (PARITY_EN != 0) begin
              state_d = TX_PARITY;
              tx_d    = parity_q;
            end else begin
              state_d  = TX_STOP;
              tx_d     = 1'b1;
              stop_clr = 1'b1;
            end
          end else begin
            idx_inc = 1'b1;
            tx_d    = shreg_q[1];
          end
        end
      end
      TX_PARITY: begin
        if (bit_end) begin
          state_d  = TX_STOP;
          tx_d     = 1'b1;
          stop_clr = 1'b1;
        end
      end
      TX_STOP: begin
        tx_d = 1'b1;
        if (bit_end) begin
          if (stop_cnt_q == STOP_LAST) begin
            state_d = TX_IDLE;
            done_d  = 1'b1;
          end else begin
            stop_inc = 1'b1;
          end
        end
      end
      default: begin
        state_d = TX_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= TX_IDLE;
      tx_q       <= 1'b1;
      shreg_q    <= '0;
      parity_q   <= 1'b0;
      bit_idx_q  <= '0;
      stop_cnt_q <= 1'b0;
      tx_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_q      <= tx_d;
      tx_done_q <= done_d;
      if (load) begin
        shreg_q    <= tx_data;
        parity_q   <= (^tx_data) ^ (PARITY_ODD != 0);
        bit_idx_q  <= '0;
        stop_cnt_q <= 1'b0;
      end else begin
        if (shift)   shreg_q   <= {1'b0, shreg_q[DATA_BITS-1:1]};
        if (idx_inc) bit_idx_q <= bit_idx_q + IW'(1);
        if (stop_clr)      stop_cnt_q <= 1'b0;
        else if (stop_inc) stop_cnt_q <= 1'b1;
      end
    end
  end

  assign tx_ready  = (state_q == TX_IDLE);
  assign busy      = !tx_ready;
  assign tx        = tx_q;
  assign tx_done   = tx_done_q;
  assign state_dbg = state_q;

endmodule
